rob_mc: RTL and testbench

Parametrised next-generation reorder buffer for the superscalar pipeline: circular buffer with wrap-bit pointers, multi-slot reserve/write/commit and per-port associative operand lookup.
- Adds over the current ROB: configurable data width and lookup port count, a hi/lo result pair, per-entry exception flag, commit of only contiguous completed heads, and exact flush recovery across wrap-around.
- Sits between decode/issue (reserve, lookup), execution units (write) and the register-file commit stage (consume).

---
 rtl/rob_mc_pkg.sv | 18 +
 rtl/rob_mc_lu.sv | 39 +++
 rtl/rob_mc.sv | 170 +++++++++++++++++
 tb/tb_rob_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_mc_pkg.sv
// rob_mc_pkg: shared widths and entry/pointer types for the rob_mc reorder buffer.
package rob_mc_pkg;
    localparam int RM_DEPTH     = 16;
    localparam int RM_DATA_W    = 32;
    localparam int RM_DEPTHLOG2 = $clog2(RM_DEPTH);

    // Slot index plus one wrap bit, so full and empty stay distinguishable.
    typedef logic [RM_DEPTHLOG2:0] rob_ptr_t;

    typedef struct packed {
        logic [RM_DATA_W-1:0] result_lo;
        logic [RM_DATA_W-1:0] result_hi;
        logic [4:0]           dest_reg;
        logic                 dest_reg_valid;
        logic                 exc;
        logic                 done;
    } rob_mc_entry_t;
endpackage

// File: rtl/rob_mc_lu.sv
// rob_lu_search: youngest in-flight producer strictly older than the querying slot, for one lookup port.
module rob_lu_search #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTHLOG2 = $clog2(DEPTH)
) (
    input  logic [4:0]           dest_i [DEPTH],
    input  logic [DEPTH-1:0]     dv_i,
    input  logic [DEPTH-1:0]     done_i,
    input  logic [DATA_W-1:0]    lo_i [DEPTH],
    input  logic [DEPTHLOG2-1:0] head_i,
    input  logic [DEPTHLOG2:0]   used_i,
    input  logic [DEPTHLOG2-1:0] idx_i,
    input  logic [4:0]           reg_i,
    output logic                 hit_o,
    output logic                 ready_o,
    output logic [DATA_W-1:0]    val_o
);
    logic [DEPTHLOG2-1:0] span, slot;

    assign span = idx_i - head_i;

    // Walk from oldest to youngest; the last qualifying match is the youngest older producer.
    always_comb begin
        hit_o   = 1'b0;
        ready_o = 1'b0;
        val_o   = '0;
        slot    = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + DEPTHLOG2'(k);
            if (DEPTHLOG2'(k) < span && (DEPTHLOG2+1)'(k) < used_i && reg_i != 5'd0 &&
                dv_i[slot] && dest_i[slot] == reg_i) begin
                hit_o   = 1'b1;
                ready_o = done_i[slot];
                val_o   = done_i[slot] ? lo_i[slot] : '0;
            end
        end
    end
endmodule

// File: rtl/rob_mc.sv
// rob_mc: circular reorder buffer with multi-slot reserve/write/commit, flush recovery and operand lookup.
module rob_mc
    import rob_mc_pkg::*;
#(
    parameter int DEPTH      = RM_DEPTH,
    parameter int DATA_W     = RM_DATA_W,
    parameter int INS_COUNT  = 4,
    parameter int EXT_COUNT  = 4,
    parameter int WR_COUNT   = 4,
    parameter int LU_COUNT   = 4,
    parameter int FLUSH_KEEP = 2,
    parameter int DEPTHLOG2  = $clog2(DEPTH),
    localparam int PW  = DEPTHLOG2 + 1,
    localparam int RCW = $clog2(INS_COUNT + 1),
    localparam int CCW = $clog2(EXT_COUNT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reserve,
    input  logic [RCW-1:0]       reserve_count,
    output logic                 reserve_ack,
    output logic [DEPTHLOG2-1:0] reserved_slots [INS_COUNT],
    input  logic [4:0]           dest_reg [INS_COUNT],
    input  logic [INS_COUNT-1:0] dest_reg_valid,
    input  logic [WR_COUNT-1:0]  write_valid,
    input  logic [DEPTHLOG2-1:0] write_slot [WR_COUNT],
    input  logic [DATA_W-1:0]    write_lo [WR_COUNT],
    input  logic [DATA_W-1:0]    write_hi [WR_COUNT],
    input  logic [WR_COUNT-1:0]  write_exc,
    input  logic [DEPTHLOG2-1:0] lu_idx [LU_COUNT],
    input  logic [4:0]           lu_reg [LU_COUNT],
    output logic [LU_COUNT-1:0]  lu_hit,
    output logic [LU_COUNT-1:0]  lu_ready,
    output logic [DATA_W-1:0]    lu_val [LU_COUNT],
    output logic [EXT_COUNT-1:0] head_valid,
    output logic [DEPTHLOG2-1:0] head_slot [EXT_COUNT],
    output logic [4:0]           head_dest_reg [EXT_COUNT],
    output logic [EXT_COUNT-1:0] head_dest_valid,
    output logic [DATA_W-1:0]    head_lo [EXT_COUNT],
    output logic [DATA_W-1:0]    head_hi [EXT_COUNT],
    output logic [EXT_COUNT-1:0] head_exc,
    input  logic [CCW-1:0]       consume_count,
    input  logic                 flush,
    input  logic [DEPTHLOG2-1:0] flush_idx,
    output logic [PW-1:0]        used_count,
    output logic [PW-1:0]        free_count,
    output logic                 empty,
    output logic                 full
);
    rob_ptr_t             head_q, head_d, tail_q, tail_d, tail_f;
    rob_mc_entry_t        ent_q [DEPTH];
    rob_mc_entry_t        ent_d [DEPTH];
    logic [PW-1:0]        used, keep, after;
    logic [DEPTHLOG2-1:0] off;
    logic [CCW-1:0]       n_valid, cons;
    logic                 chain;
    logic [4:0]           lu_dst [DEPTH];
    logic [DATA_W-1:0]    lu_lo [DEPTH];
    logic [DEPTH-1:0]     lu_dv, lu_dn;

    assign used        = tail_q - head_q;
    assign used_count  = used;
    assign free_count  = PW'(DEPTH) - used;
    assign empty       = used == '0;
    assign full        = used == PW'(DEPTH);
    assign reserve_ack = reserve & (PW'(reserve_count) <= free_count) & ~flush;

    always_comb
        for (int i = 0; i < INS_COUNT; i++)
            reserved_slots[i] = tail_q[DEPTHLOG2-1:0] + DEPTHLOG2'(i);

    always_comb begin
        chain   = 1'b1;
        n_valid = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            head_slot[i]       = head_q[DEPTHLOG2-1:0] + DEPTHLOG2'(i);
            head_valid[i]      = chain & (PW'(i) < used) & ent_q[head_slot[i]].done;
            head_dest_reg[i]   = ent_q[head_slot[i]].dest_reg;
            head_dest_valid[i] = ent_q[head_slot[i]].dest_reg_valid;
            head_lo[i]         = ent_q[head_slot[i]].result_lo;
            head_hi[i]         = ent_q[head_slot[i]].result_hi;
            head_exc[i]        = ent_q[head_slot[i]].exc;
            chain              = head_valid[i] & ~ent_q[head_slot[i]].exc;
            n_valid            = n_valid + CCW'(head_valid[i]);
        end
        cons = consume_count < n_valid ? consume_count : n_valid;
    end

    always_comb begin
        head_d = head_q + PW'(cons);
        off    = flush_idx - head_q[DEPTHLOG2-1:0];
        keep   = PW'(off) + PW'(FLUSH_KEEP);
        keep   = keep < used ? keep : used;
        keep   = keep < PW'(cons) ? PW'(cons) : keep;
        tail_f = flush ? head_q + keep : tail_q;
        tail_d = tail_f + (reserve_ack ? PW'(reserve_count) : PW'(0));
        after  = tail_f - head_d;
    end

    always_comb begin
        ent_d = ent_q;
        for (int w = 0; w < WR_COUNT; w++)
            if (write_valid[w] && {1'b0, write_slot[w] - head_d[DEPTHLOG2-1:0]} < after) begin
                ent_d[write_slot[w]].result_lo = write_lo[w];
                ent_d[write_slot[w]].result_hi = write_hi[w];
                ent_d[write_slot[w]].exc       = write_exc[w];
                ent_d[write_slot[w]].done      = 1'b1;
            end
        for (int i = 0; i < INS_COUNT; i++)
            if (reserve_ack && RCW'(i) < reserve_count) begin
                ent_d[reserved_slots[i]].dest_reg       = dest_reg[i];
                ent_d[reserved_slots[i]].dest_reg_valid = dest_reg_valid[i];
                ent_d[reserved_slots[i]].exc            = 1'b0;
                ent_d[reserved_slots[i]].done           = 1'b0;
            end
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            ent_q  <= '{default: '0};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ent_q  <= ent_d;
        end

    always_comb
        for (int e = 0; e < DEPTH; e++) begin
            lu_dst[e] = ent_q[e].dest_reg;
            lu_dv[e]  = ent_q[e].dest_reg_valid;
            lu_dn[e]  = ent_q[e].done;
            lu_lo[e]  = ent_q[e].result_lo;
        end

    for (genvar g = 0; g < LU_COUNT; g++) begin : g_lu
        rob_lu_search #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DEPTHLOG2(DEPTHLOG2)) u_lu (
            .dest_i (lu_dst),
            .dv_i   (lu_dv),
            .done_i (lu_dn),
            .lo_i   (lu_lo),
            .head_i (head_q[DEPTHLOG2-1:0]),
            .used_i (used),
            .idx_i  (lu_idx[g]),
            .reg_i  (lu_reg[g]),
            .hit_o  (lu_hit[g]),
            .ready_o(lu_ready[g]),
            .val_o  (lu_val[g])
        );
    end

`ifdef ROB_TRACE_EN
    always @(posedge clock) begin
        $display("rob_mc head=%0d tail=%0d used=%0d", head_q, tail_q, used);
        for (int i = 0; i < INS_COUNT; i++)
            if (reserve_ack && RCW'(i) < reserve_count)
                $display("  rsv slot=%0d dest=%0d", reserved_slots[i], dest_reg[i]);
        for (int w = 0; w < WR_COUNT; w++)
            if (write_valid[w])
                $display("  wr slot=%0d lo=%h exc=%0d", write_slot[w], write_lo[w], write_exc[w]);
        for (int i = 0; i < EXT_COUNT; i++)
            if (CCW'(i) < cons)
                $display("  commit slot=%0d dest=%0d lo=%h exc=%0d",
                         head_slot[i], head_dest_reg[i], head_lo[i], head_exc[i]);
        if (flush)
            $display("  flush slot=%0d new_tail=%0d", flush_idx, tail_f);
    end
`endif
endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed plus randomized checks of rob_mc against a queue-based reference model.
module tb_rob_mc;
    localparam int DEPTH = 16, INS = 4, EXT = 4, WR = 4, LU = 4, KEEP = 2, L = 4;

    logic clock = 1'b0, reset = 1'b0;
    logic reserve, reserve_ack, flush, empty, full;
    logic [2:0] reserve_count, consume_count;
    logic [L-1:0] reserved_slots [INS];
    logic [4:0] dest_reg [INS];
    logic [INS-1:0] dest_reg_valid;
    logic [WR-1:0] write_valid, write_exc;
    logic [L-1:0] write_slot [WR];
    logic [31:0] write_lo [WR];
    logic [31:0] write_hi [WR];
    logic [L-1:0] lu_idx [LU];
    logic [4:0] lu_reg [LU];
    logic [LU-1:0] lu_hit, lu_ready;
    logic [31:0] lu_val [LU];
    logic [EXT-1:0] head_valid, head_dest_valid, head_exc;
    logic [L-1:0] head_slot [EXT];
    logic [4:0] head_dest_reg [EXT];
    logic [31:0] head_lo [EXT];
    logic [31:0] head_hi [EXT];
    logic [L-1:0] flush_idx;
    logic [L:0] used_count, free_count;

    always #5 clock = ~clock;

    rob_mc dut (
        .clock(clock), .reset(reset), .reserve(reserve), .reserve_count(reserve_count),
        .reserve_ack(reserve_ack), .reserved_slots(reserved_slots), .dest_reg(dest_reg),
        .dest_reg_valid(dest_reg_valid), .write_valid(write_valid), .write_slot(write_slot),
        .write_lo(write_lo), .write_hi(write_hi), .write_exc(write_exc), .lu_idx(lu_idx),
        .lu_reg(lu_reg), .lu_hit(lu_hit), .lu_ready(lu_ready), .lu_val(lu_val),
        .head_valid(head_valid), .head_slot(head_slot), .head_dest_reg(head_dest_reg),
        .head_dest_valid(head_dest_valid), .head_lo(head_lo), .head_hi(head_hi),
        .head_exc(head_exc), .consume_count(consume_count), .flush(flush),
        .flush_idx(flush_idx), .used_count(used_count), .free_count(free_count),
        .empty(empty), .full(full)
    );

    typedef struct {
        int          dest;
        bit          dv;
        bit          done;
        bit          exc;
        logic [31:0] lo;
        logic [31:0] hi;
    } me_t;

    me_t q[$];
    int mhead = 0, checks = 0, failures = 0, m_nv = 0;
    bit m_ack = 0;
    bit [EXT-1:0] m_hv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        reserve = 0; reserve_count = 0; consume_count = 0; flush = 0; flush_idx = 0;
        dest_reg_valid = 0; write_valid = 0; write_exc = 0;
        for (int i = 0; i < INS; i++) dest_reg[i] = 0;
        for (int w = 0; w < WR; w++) begin write_slot[w] = 0; write_lo[w] = 0; write_hi[w] = 0; end
        for (int p = 0; p < LU; p++) begin lu_idx[p] = 0; lu_reg[p] = 0; end
    endtask

    task automatic compare();
        int sz, off, lim;
        bit chain, v, eh, er;
        logic [31:0] ev;
        sz = q.size();
        m_ack = reserve && int'(reserve_count) <= DEPTH - sz && !flush;
        chk("ack", reserve_ack, m_ack);
        chk("used", used_count, sz);
        chk("free", free_count, DEPTH - sz);
        chk("empty", empty, sz == 0);
        chk("full", full, sz == DEPTH);
        for (int i = 0; i < INS; i++) chk("rslot", reserved_slots[i], (mhead + sz + i) % DEPTH);
        chain = 1; m_nv = 0;
        for (int i = 0; i < EXT; i++) begin
            v = 0;
            if (chain && i < sz) v = q[i].done;
            m_hv[i] = v;
            if (v) begin
                m_nv++;
                chk("hslot", head_slot[i], (mhead + i) % DEPTH);
                chk("hdest", head_dest_reg[i], q[i].dest);
                chk("hdv", head_dest_valid[i], q[i].dv);
                chk("hlo", head_lo[i], q[i].lo);
                chk("hhi", head_hi[i], q[i].hi);
                chk("hexc", head_exc[i], q[i].exc);
                chain = !q[i].exc;
            end else chain = 0;
        end
        chk("hv", head_valid, m_hv);
        for (int p = 0; p < LU; p++) begin
            off = (int'(lu_idx[p]) - mhead + DEPTH) % DEPTH;
            lim = off < sz ? off : sz;
            eh = 0; er = 0; ev = 0;
            for (int j = lim - 1; j >= 0; j--)
                if (!eh && lu_reg[p] != 0 && q[j].dv && q[j].dest == int'(lu_reg[p])) begin
                    eh = 1; er = q[j].done; ev = er ? q[j].lo : 32'd0;
                end
            chk("lu_hit", lu_hit[p], eh);
            chk("lu_ready", lu_ready[p], er);
            chk("lu_val", lu_val[p], ev);
        end
    endtask

    task automatic update();
        int sz0, cons, keep, off;
        me_t e;
        sz0 = q.size();
        cons = int'(consume_count) < m_nv ? int'(consume_count) : m_nv;
        off = (int'(flush_idx) - mhead + DEPTH) % DEPTH;
        repeat (cons) void'(q.pop_front());
        mhead = (mhead + cons) % DEPTH;
        if (flush) begin
            keep = (off + KEEP < sz0 ? off + KEEP : sz0) - cons;
            while (q.size() > (keep < 0 ? 0 : keep)) void'(q.pop_back());
        end
        for (int w = 0; w < WR; w++) begin
            off = (int'(write_slot[w]) - mhead + DEPTH) % DEPTH;
            if (write_valid[w] && off < q.size()) begin
                q[off].done = 1; q[off].exc = write_exc[w];
                q[off].lo = write_lo[w]; q[off].hi = write_hi[w];
            end
        end
        if (m_ack)
            for (int i = 0; i < int'(reserve_count); i++) begin
                e.dest = int'(dest_reg[i]); e.dv = dest_reg_valid[i];
                e.done = 0; e.exc = 0; e.lo = 0; e.hi = 0;
                q.push_back(e);
            end
    endtask

    task automatic step();
        #1;
        compare();
        update();
        @(negedge clock);
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        #1;
        chk("rst_used", used_count, 0);
        chk("rst_free", free_count, 16);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_hv", head_valid, 0);
        chk("rst_ack", reserve_ack, 0);
        chk("rst_lu", lu_hit, 0);
        q.delete();
        mhead = 0;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic rsv(input int n, input int d);
        clear_in();
        reserve = 1; reserve_count = 3'(n);
        for (int i = 0; i < INS; i++) begin dest_reg[i] = 5'(d); dest_reg_valid[i] = 1; end
        step();
    endtask

    task automatic wr(input int s, input logic [31:0] lo, input bit e);
        clear_in();
        write_valid[0] = 1; write_slot[0] = L'(s); write_lo[0] = lo; write_hi[0] = ~lo; write_exc[0] = e;
        step();
    endtask

    task automatic cons(input int n);
        clear_in();
        consume_count = 3'(n);
        step();
    endtask

    task automatic rand_cycle();
        int sz;
        clear_in();
        sz = q.size();
        reserve = 1'($urandom % 2);
        reserve_count = 3'($urandom_range(0, INS));
        for (int i = 0; i < INS; i++) begin
            dest_reg[i] = 5'($urandom_range(0, 7));
            dest_reg_valid[i] = ($urandom % 4) != 0;
        end
        for (int w = 0; w < WR; w++) begin
            write_valid[w] = 1'($urandom % 2);
            write_slot[w] = (sz > 0 && ($urandom % 4) != 0) ? L'((mhead + int'($urandom % 32'(sz))) % DEPTH)
                                                            : L'($urandom % DEPTH);
            write_lo[w] = $urandom;
            write_hi[w] = $urandom;
            write_exc[w] = ($urandom % 8) == 0;
        end
        consume_count = 3'($urandom_range(0, EXT));
        if (sz > 0 && ($urandom % 10) == 0) begin
            flush = 1;
            flush_idx = L'((mhead + int'($urandom % 32'(sz))) % DEPTH);
        end
        for (int p = 0; p < LU; p++) begin
            lu_idx[p] = L'($urandom % DEPTH);
            lu_reg[p] = 5'($urandom_range(0, 7));
        end
        step();
    endtask

    initial begin
        clear_in();
        do_reset();
        // Fill to full, then a further request must be refused.
        repeat (4) rsv(4, 1);
        chk("t1_full", full, 1);
        chk("t1_used", used_count, 16);
        clear_in();
        reserve = 1; reserve_count = 3'd1;
        #1;
        chk("t1_ack", reserve_ack, 0);
        step();
        // Out-of-order completion: commit waits for slot 0.
        do_reset();
        rsv(3, 1);
        wr(1, 32'h11, 0);
        chk("t2_hv0", head_valid, 4'b0000);
        wr(0, 32'h22, 0);
        chk("t2_hv", head_valid, 4'b0011);
        cons(4);
        chk("t2_head", head_slot[0], 2);
        chk("t2_used", used_count, 1);
        // Wrap-around flush.
        do_reset();
        repeat (3) rsv(4, 1);
        rsv(2, 1);
        for (int s = 0; s < 14; s++) wr(s, 32'(s + 100), 0);
        repeat (3) cons(4);
        cons(2);
        chk("t3_head", head_slot[0], 14);
        chk("t3_empty", empty, 1);
        rsv(4, 1);
        chk("t3_tail", reserved_slots[0], 2);
        clear_in();
        flush = 1; flush_idx = 4'd15;
        step();
        chk("t3_used", used_count, 3);
        chk("t3_tailw", reserved_slots[0], 1);
        // Lookup age ordering.
        do_reset();
        clear_in();
        reserve = 1; reserve_count = 3'd4; dest_reg_valid = 4'hF;
        dest_reg = '{5'd3, 5'd3, 5'd7, 5'd3};
        step();
        clear_in();
        reserve = 1; reserve_count = 3'd4; dest_reg_valid = 4'hF;
        dest_reg = '{5'd3, 5'd7, 5'd3, 5'd3};
        step();
        wr(2, 32'hAB, 0);
        clear_in();
        lu_idx[0] = 4'd6; lu_reg[0] = 5'd7;
        lu_idx[1] = 4'd4; lu_reg[1] = 5'd7;
        lu_idx[2] = 4'd4; lu_reg[2] = 5'd0;
        #1;
        chk("t4_hit6", lu_hit[0], 1);
        chk("t4_rdy6", lu_ready[0], 0);
        chk("t4_hit4", lu_hit[1], 1);
        chk("t4_rdy4", lu_ready[1], 1);
        chk("t4_val4", lu_val[1], 32'hAB);
        chk("t4_r0", lu_hit[2], 0);
        step();
        // Exception masks younger entries.
        do_reset();
        rsv(4, 2);
        clear_in();
        write_valid = 4'hF; write_exc = 4'b0010;
        for (int w = 0; w < WR; w++) begin write_slot[w] = L'(w); write_lo[w] = 32'(w + 1); end
        step();
        chk("t5_hv", head_valid, 4'b0011);
        chk("t5_exc", head_exc[1], 1);
        // Write, flush and consume in one cycle.
        do_reset();
        repeat (3) rsv(4, 1);
        wr(0, 32'h55, 0);
        clear_in();
        write_valid[0] = 1; write_slot[0] = 4'd9; write_lo[0] = 32'h99;
        flush = 1; flush_idx = 4'd5; consume_count = 3'd1;
        step();
        chk("t6_used", used_count, 6);
        chk("t6_head", head_slot[0], 1);
        // Randomized traffic with a mid-run reset.
        repeat (800) rand_cycle();
        do_reset();
        repeat (1200) rand_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
